// File: rtl/vga_pkg.sv
// Shared VGA timing constants, tile-fetch FSM encoding and address helper.
// Used by the sync generator and the line fetcher.
package vga_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_TOTAL   = 800;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_TOTAL   = 525;
    localparam int VGA_TILES     = VGA_H_DISPLAY / 8;
    localparam int TILE_COLOUR_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    // Full-width tile address: line*tiles + col (max 479*80+79 fits in 16 bits).
    function automatic logic [15:0] tile_addr(input logic [15:0] line,
                                              input logic [15:0] col,
                                              input logic [15:0] tiles);
        return line * tiles + col;
    endfunction

endpackage

// File: rtl/vga_line_buffer.sv
// Two-bank tile colour line buffer: one write port and one synchronous read
// port, each with its own bank select. Contents are never reset.
module vga_line_buffer
    import vga_pkg::*;
#(
    parameter int DEPTH = VGA_TILES,
    parameter int WIDTH = TILE_COLOUR_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Out-of-range columns read as black rather than undefined data.
    always_ff @(posedge clk) begin
        if (int'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_bank][rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/vga_line_fetcher.sv
// Prefetches the tile colours of the next visible line into a ping-pong line
// buffer while the current line is displayed from the other bank.
module vga_line_fetcher
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_TOTAL   = VGA_V_TOTAL,
    parameter int TILES     = VGA_TILES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [9:0]   hpos,
    input  logic [9:0]   vpos,
    input  logic         display_on,
    output logic         mem_req,
    output logic [15:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [5:0]   mem_rdata,
    output logic [5:0]   rgb,
    output logic         fetch_busy,
    output logic         underrun,
    input  logic         underrun_clr,
    output fetch_state_e state_dbg
);

    localparam int COL_W = $clog2(TILES);

    fetch_state_e     state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [9:0]       line_q, line_d;
    logic             gap_q, gap_d;
    logic             bank_q;
    logic             underrun_q;
    logic             display_on_q;

    logic             trigger;
    logic [9:0]       next_line;
    logic             fetch_start;
    logic             last_col;
    logic             wr_en;
    logic [5:0]       rd_data;

    assign trigger     = (hpos == 10'(H_DISPLAY));
    assign next_line   = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    assign fetch_start = trigger && (next_line < 10'(V_DISPLAY));
    assign last_col    = (col_q == COL_W'(TILES - 1));

    // Handshake: mem_req stays high with mem_addr stable until a rising edge
    // with mem_ack=1 (mem_rdata captured on that edge); mem_ack is ignored while
    // mem_req is low; after each accepted beat mem_req drops for one cycle.
    assign mem_req    = (state_q == ST_REQ) && !gap_q;
    assign mem_addr   = tile_addr(16'(line_q), 16'(col_q), 16'(TILES));
    assign fetch_busy = (state_q == ST_REQ);
    assign underrun   = underrun_q;
    assign state_dbg  = state_q;
    assign rgb        = display_on_q ? rd_data : 6'd0;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        gap_d   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_REQ: begin
                if (!gap_q && mem_ack) begin
                    wr_en = 1'b1;
                    if (last_col) begin
                        state_d = ST_DONE;
                    end else begin
                        col_d = col_q + COL_W'(1);
                        gap_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A line trigger overrides everything: an in-flight beat is dropped.
        if (fetch_start) begin
            state_d = ST_REQ;
            col_d   = '0;
            line_d  = next_line;
            gap_d   = 1'b0;
            wr_en   = 1'b0;
        end else if (trigger && (state_q == ST_REQ)) begin
            state_d = ST_IDLE;
            gap_d   = 1'b0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            line_q       <= '0;
            gap_q        <= 1'b0;
            bank_q       <= 1'b0;
            underrun_q   <= 1'b0;
            display_on_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            line_q       <= line_d;
            gap_q        <= gap_d;
            display_on_q <= display_on;
            if (trigger) begin
                bank_q <= ~bank_q;
            end
            if (trigger && (state_q == ST_REQ)) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

    vga_line_buffer #(
        .DEPTH (TILES),
        .WIDTH (6),
        .AW    (COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (~bank_q),
        .wr_addr (col_q),
        .wr_data (mem_rdata),
        .rd_bank (bank_q),
        .rd_addr (COL_W'(hpos[9:3])),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench for vga_line_fetcher: fetch sequencing, frame wrap, display
// readback, underrun handling and mid-fetch reset.
module tb_vga_line_fetcher;
    import vga_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [9:0]   hpos;
    logic [9:0]   vpos;
    logic         display_on;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_ack;
    logic [5:0]   mem_rdata;
    logic [5:0]   rgb;
    logic         fetch_busy;
    logic         underrun;
    logic         underrun_clr;
    fetch_state_e state_dbg;

    logic [5:0]   rdata_xor;
    logic [15:0]  exp_q[$];
    int           n_checks;
    int           n_errors;

    // Tile memory model: colour = (col % 64) ^ rdata_xor.
    assign mem_rdata = 6'((mem_addr % 16'd80) % 16'd64) ^ rdata_xor;

    vga_line_fetcher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hpos         (hpos),
        .vpos         (vpos),
        .display_on   (display_on),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .rgb          (rgb),
        .fetch_busy   (fetch_busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger_line(input logic [9:0] v);
        vpos = v;
        hpos = 10'd640;
        step();
        hpos = 10'd641;
    endtask

    // Follow a fetch with mem_ack tied high; called just after the trigger edge.
    task automatic collect_fetch(input string tag, input int base);
        int n;
        int last;
        logic [15:0] exp;
        n = 0;
        last = -1;
        exp_q.delete();
        for (int i = 0; i < 80; i++) exp_q.push_back(16'(base + i));
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (mem_req) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
                check_eq({tag, "_addr"}, 32'(mem_addr), 32'(exp));
                if (last >= 0) check_eq({tag, "_spacing"}, 32'(cyc - last), 32'd2);
                last = cyc;
                n++;
            end
            if (!fetch_busy) break;
            step();
        end
        check_eq({tag, "_beats"}, 32'(n), 32'd80);
        check_eq({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_busy_end"}, 32'(fetch_busy), 32'd0);
        check_eq({tag, "_req_end"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        int found;
        int req_seen;
        int rgb_k[6];
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        hpos = 10'd0;
        vpos = 10'd0;
        display_on = 1'b0;
        mem_ack = 1'b0;
        underrun_clr = 1'b0;
        rdata_xor = 6'h00;

        // Reset state
        step();
        step();
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_rgb", 32'(rgb), 32'd0);
        check_eq("rst_busy", 32'(fetch_busy), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        hpos = 10'd641;
        step();
        check_eq("no_fetch_before_trigger", 32'(mem_req), 32'd0);

        // Line 11 fetch with ack tied high: 880..959
        mem_ack = 1'b1;
        rdata_xor = 6'h3F;
        trigger_line(10'd10);
        check_eq("l11_state", 32'(state_dbg), 32'(ST_REQ));
        collect_fetch("l11", 880);
        check_eq("l11_underrun", 32'(underrun), 32'd0);
        step();
        check_eq("l11_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Frame wrap: vpos 524 fetches line 0
        rdata_xor = 6'h00;
        trigger_line(10'd524);
        collect_fetch("l0", 0);
        step();

        // vpos 479: line 480 is not visible, no fetch
        trigger_line(10'd479);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req || fetch_busy) req_seen++;
            step();
        end
        check_eq("l480_no_req", 32'(req_seen), 32'd0);

        // Display readback: bank now shows line 0 data (col % 64)
        for (int h = 0; h < 640; h++) begin
            hpos = 10'(h);
            display_on = 1'b1;
            step();
            check_eq("rgb_sweep", 32'(rgb), 32'((h / 8) % 64));
        end
        hpos = 10'd8;
        display_on = 1'b0;
        step();
        check_eq("rgb_blank", 32'(rgb), 32'd0);
        hpos = 10'd641;
        step();

        // Slow memory: ack only after 20 cycles per beat
        mem_ack = 1'b0;
        trigger_line(10'd20);
        repeat (20) step();
        check_eq("slow_hold_req", 32'(mem_req), 32'd1);
        check_eq("slow_hold_addr", 32'(mem_addr), 32'd1680);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_eq("slow_gap_req", 32'(mem_req), 32'd0);
        check_eq("slow_gap_busy", 32'(fetch_busy), 32'd1);
        step();
        check_eq("slow_beat1_addr", 32'(mem_addr), 32'd1681);
        check_eq("slow_beat1_req", 32'(mem_req), 32'd1);
        repeat (20) step();
        check_eq("slow_no_underrun_yet", 32'(underrun), 32'd0);
        trigger_line(10'd21);
        check_eq("underrun_set", 32'(underrun), 32'd1);
        check_eq("underrun_restart_addr", 32'(mem_addr), 32'd1760);
        check_eq("underrun_restart_req", 32'(mem_req), 32'd1);
        check_eq("underrun_state", 32'(state_dbg), 32'(ST_REQ));
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check_eq("underrun_cleared", 32'(underrun), 32'd0);
        step();
        underrun_clr = 1'b1;
        trigger_line(10'd22);
        underrun_clr = 1'b0;
        check_eq("underrun_clr_loses", 32'(underrun), 32'd1);
        check_eq("underrun2_addr", 32'(mem_addr), 32'd1840);
        mem_ack = 1'b1;
        for (int i = 0; i < 400 && fetch_busy; i++) step();
        check_eq("slow_drain_busy", 32'(fetch_busy), 32'd0);
        step();

        // Reset during beat 40 of line 31
        trigger_line(10'd30);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (mem_req && mem_addr == 16'd2520) begin
                found = 1;
                break;
            end
            step();
        end
        check_eq("beat40_found", 32'(found), 32'd1);
        rst_n = 1'b0;
        display_on = 1'b1;
        hpos = 10'd16;
        step();
        rst_n = 1'b1;
        check_eq("midrst_req", 32'(mem_req), 32'd0);
        check_eq("midrst_rgb", 32'(rgb), 32'd0);
        check_eq("midrst_busy", 32'(fetch_busy), 32'd0);
        check_eq("midrst_underrun", 32'(underrun), 32'd0);
        check_eq("midrst_addr", 32'(mem_addr), 32'd0);
        display_on = 1'b0;
        hpos = 10'd641;
        req_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_req || state_dbg != ST_IDLE) req_seen++;
        end
        check_eq("midrst_late_ack_ignored", 32'(req_seen), 32'd0);
        rdata_xor = 6'h15;
        trigger_line(10'd30);
        check_eq("midrst_restart_addr", 32'(mem_addr), 32'd2480);
        collect_fetch("l31", 2480);
        step();
        trigger_line(10'd479);
        check_eq("l480b_no_req", 32'(mem_req), 32'd0);
        rgb_k = '{0, 1, 40, 63, 64, 79};
        foreach (rgb_k[i]) begin
            hpos = 10'(8 * rgb_k[i] + 3);
            display_on = 1'b1;
            step();
            check_eq("rgb_after_rst", 32'(rgb), 32'(6'(rgb_k[i] % 64) ^ 6'h15));
        end
        display_on = 1'b0;
        step();
        check_eq("rgb_final_blank", 32'(rgb), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_line_fetcher.md
VGA_LINE_FETCHER -- requirements
Module: vga_line_fetcher

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter V_DISPLAY, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter V_TOTAL, default 525, meaning total lines per frame (vpos wraps at V_TOTAL-1).
REQ-004 SHALL have parameter TILES, default 80, meaning 8-pixel tiles per line (H_DISPLAY/8).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port hpos, input, 10, current pixel column from the sync generator.
REQ-008 SHALL have port vpos, input, 10, current line from the sync generator.
REQ-009 SHALL have port display_on, input, 1, high inside the visible area.
REQ-010 SHALL have port mem_req, output, 1, fetch request to tile memory.
REQ-011 SHALL have port mem_addr, output, 16, tile address = line*TILES + col.
REQ-012 SHALL have port mem_ack, input, 1, memory accepts the request; mem_rdata is valid in the same cycle.
REQ-013 SHALL have port mem_rdata, input, 6, tile colour {R[1:0],G[1:0],B[1:0]}.
REQ-014 SHALL have port rgb, output, 6, pixel colour to the TinyVGA output mapping.
REQ-015 SHALL have port fetch_busy, output, 1, high while a line fetch is in progress.
REQ-016 SHALL have ports underrun, output, 1, sticky error flag, and underrun_clr, input, 1, clears the flag.

Function
REQ-017 SHALL hold two TILES-entry 6-bit line buffers (ping-pong): one is the display bank and the other is the fill bank.
REQ-018 SHALL generate a line trigger in the cycle where hpos == H_DISPLAY.
REQ-019 SHALL set next_line = 0 when vpos == V_TOTAL-1, and next_line = vpos+1 otherwise.
REQ-020 SHALL, on each trigger, swap display and fill banks, and start a fetch only if next_line < V_DISPLAY.
REQ-021 SHALL use FSM states IDLE, REQ, DONE with these transitions: IDLE->REQ on a qualifying trigger; REQ->REQ on ack with col < TILES-1; REQ->DONE on ack with col == TILES-1; DONE->IDLE next cycle; any state->REQ with col=0 on a qualifying trigger.
REQ-022 SHALL keep mem_req high and mem_addr stable in REQ until a clock edge with mem_ack=1; mem_rdata is written to fill[col] on that edge; the next request may be presented in the following cycle (1 beat per 2 cycles minimum).
REQ-023 SHALL compute mem_addr at full 16-bit width with no truncation; the maximum value is 479*80+79 = 38399.
REQ-024 SHALL ignore mem_ack when mem_req is low.
REQ-025 SHALL, if a trigger arrives while state is REQ, set underrun=1, abort the fetch, leave unfetched entries stale and restart per REQ-021; the swap still occurs.
REQ-026 SHALL give underrun_clr lower priority than a simultaneous underrun set: the flag stays 1.
REQ-027 SHALL register rgb (1-cycle latency): rgb <= display_on ? display[hpos[9:3]] : 0.
REQ-028 SHALL assert fetch_busy exactly when state is REQ.

Reset
REQ-029 SHALL, with rst_n low at a clock edge, set state=IDLE, mem_req=0, mem_addr=0, rgb=0, fetch_busy=0, underrun=0 and bank select=0; buffer contents are not cleared.
REQ-030 SHALL, on reset mid-fetch, drop mem_req in the next cycle; a late mem_ack is ignored.
REQ-031 SHALL not fetch until the first trigger after reset release; lines displayed before the first completed fetch are stale data, which is permitted.

Structure
REQ-032 SHALL place the timing constants (H_DISPLAY, V_DISPLAY, V_TOTAL, TILES) and the FSM state encoding in shared package vga_pkg, which is also used by the sync generator.
REQ-033 SHALL implement the two banks as one sub-module vga_line_buffer with 1 write port and 1 read port, a bank select per port, and a synchronous read.

Verification
REQ-034 SHALL cover: mem_ack tied 1, vpos=10, hpos reaches 640 -> 80 requests with addrs 880..959 at 2-cycle spacing, fetch_busy low after the last, no underrun.
REQ-035 SHALL cover: vpos=524 trigger -> addrs 0..79 fetched; at vpos=479 trigger -> no mem_req (line 480 not visible).
REQ-036 SHALL cover: memory returns rdata=col%64, then the next line is displayed -> rgb at hpos=8*k+j equals k%64, one cycle later, and 0 when display_on=0.
REQ-037 SHALL cover: ack withheld for 20 cycles per beat -> second trigger sets underrun=1 and the new fetch restarts at col 0; underrun_clr pulse then clears it; clr coincident with a new underrun -> stays 1.
REQ-038 SHALL cover: rst_n low for 1 cycle during beat 40 -> mem_req=0, rgb=0 next cycle; a following ack produces no write; the next trigger fetches from col 0.
